// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared states, key map and defaults for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int DEFAULT_SCAN_DIV        = 1000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Indexed by {row, col}; row 3 carries the E 0 F D bottom line of the pad.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEYMAP[{r, c}];
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// rtl/keypad_debounce_cnt.sv - enable/clear counter shared by scan window, press and release debounce
module keypad_debounce_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // done flags the enabled cycle whose increment would reach limit
  assign done = en && (count == (limit - WIDTH'(1)));

  // Counter self-clears on done so it never wraps and each window starts at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || done) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with debounce; KEYPAD_INTERNAL_SYNC_EN adds a row synchronizer
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int CNT_MAX = max_int(SCAN_DIV, DEBOUNCE_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LIMIT = CW'(SCAN_DIV);
  localparam logic [CW-1:0] DB_LIMIT   = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    rows_s;
  state_t        state, state_d;
  logic [1:0]    col, col_d;
  logic [1:0]    row, row_d;
  logic [3:0]    key_d;
  logic          key_valid_d;
  logic          cnt_en, cnt_clr, cnt_done;
  logic [CW-1:0] cnt_limit;
  logic          row_hi;
  logic          low_any;
  logic [1:0]    low_row;

`ifdef KEYPAD_INTERNAL_SYNC_EN
  logic [3:0] sync_q1, sync_q2;

  // Two-flop synchronizer; idle (all released) value on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 4'b1111;
      sync_q2 <= 4'b1111;
    end else begin
      sync_q1 <= rows_n;
      sync_q2 <= sync_q1;
    end
  end

  assign rows_s = sync_q2;
`else
  assign rows_s = rows_n;
`endif

  assign row_hi      = rows_s[row];
  assign low_any     = ~&rows_s;
  assign cols_n      = ~(4'b0001 << col);
  assign key_pressed = (state == HELD) || (state == RELEASE);

  // Lowest-index low row wins when several rows are low together
  always_comb begin
    low_row = 2'd3;
    if (!rows_s[0])      low_row = 2'd0;
    else if (!rows_s[1]) low_row = 2'd1;
    else if (!rows_s[2]) low_row = 2'd2;
  end

  keypad_debounce_cnt #(
    .WIDTH (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .limit (cnt_limit),
    .done  (cnt_done)
  );

  // Next-state logic; only the latched row is watched once a column is frozen
  always_comb begin
    state_d     = state;
    col_d       = col;
    row_d       = row;
    key_d       = key;
    key_valid_d = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_limit   = DB_LIMIT;
    case (state)
      SCAN: begin
        cnt_limit = SCAN_LIMIT;
        cnt_en    = 1'b1;
        if (cnt_done) begin
          if (low_any) begin
            row_d   = low_row;
            state_d = DEBOUNCE;
          end else begin
            col_d = col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (row_hi) begin
          cnt_clr = 1'b1;
          col_d   = col + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_en = 1'b1;
          if (cnt_done) begin
            key_d       = key_code(row, col);
            key_valid_d = 1'b1;
            state_d     = HELD;
          end
        end
      end
      HELD: begin
        if (row_hi) begin
          cnt_clr = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!row_hi) begin
          cnt_clr = 1'b1;
          state_d = HELD;
        end else begin
          cnt_en = 1'b1;
          if (cnt_done) begin
            col_d   = col + 2'd1;
            state_d = SCAN;
          end
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = SCAN;
      end
    endcase
  end

  // State, column/row latches and key outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      key       <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      row       <= row_d;
      key       <= key_d;
      key_valid <= key_valid_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] keys;
  int          checks;
  int          failures;
  int          pulses;

  keypad_scan_ctrl #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rows_n      (rows_n),
    .cols_n      (cols_n),
    .key         (key),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low when its column is driven
  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (key_valid === 1'b1) pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pulses   = 0;
    keys     = 16'h0000;
    reset    = 1'b0;
    cyc(2);
    chk("rst_cols", int'(cols_n), 4'b1110);
    chk("rst_key", int'(key), 0);
    chk("rst_kv", int'(key_valid), 0);
    chk("rst_kp", int'(key_pressed), 0);
    reset = 1'b1;

    // Idle scanning, 4 cycles per column
    cyc(3);  chk("scan_c0_last", int'(cols_n), 4'b1110);
    cyc(1);  chk("scan_c1", int'(cols_n), 4'b1101);
    cyc(4);  chk("scan_c2", int'(cols_n), 4'b1011);
    cyc(4);  chk("scan_c3", int'(cols_n), 4'b0111);
    cyc(4);  chk("scan_wrap", int'(cols_n), 4'b1110);
    chk("idle_pulses", pulses, 0);
    chk("idle_key", int'(key), 0);

    // Key 6 (row1/col2): sampled at edge 28, pulse after edge 36
    keys[6] = 1'b1;
    cyc(12); chk("deb_frozen", int'(cols_n), 4'b1011);
    cyc(7);  chk("k6_kv_early", int'(key_valid), 0);
    cyc(1);  chk("k6_kv", int'(key_valid), 1);
    chk("k6_key", int'(key), 4'h6);
    chk("k6_kp", int'(key_pressed), 1);
    chk("k6_cols", int'(cols_n), 4'b1011);
    cyc(1);  chk("k6_kv_one", int'(key_valid), 0);

    // Release bounce of 3 cycles, then final release
    cyc(3);
    keys[6] = 1'b0;
    cyc(3);  chk("bounce_kp", int'(key_pressed), 1);
    keys[6] = 1'b1;
    cyc(2);  chk("bounce_back_kp", int'(key_pressed), 1);
    cyc(1);
    keys[6] = 1'b0;
    cyc(8);  chk("rel_kp_hold", int'(key_pressed), 1);
    cyc(1);  chk("rel_kp_drop", int'(key_pressed), 0);
    chk("rel_cols_c3", int'(cols_n), 4'b0111);
    chk("rel_pulses", pulses, 1);

    // Key 0 (row3/col1) with a glitch after 5 debounce counts
    keys[13] = 1'b1;
    cyc(17);
    keys[13] = 1'b0;
    cyc(1);  chk("glitch_cols_c2", int'(cols_n), 4'b1011);
    chk("glitch_kp", int'(key_pressed), 0);
    chk("glitch_key", int'(key), 4'h6);
    keys[13] = 1'b1;
    cyc(23); chk("k0_kv_early", int'(key_valid), 0);
    chk("glitch_pulses", pulses, 1);
    cyc(1);  chk("k0_kv", int'(key_valid), 1);
    chk("k0_key", int'(key), 4'h0);
    chk("k0_cols", int'(cols_n), 4'b1101);
    keys = 16'h0000;
    cyc(8);  chk("k0_rel_kp", int'(key_pressed), 1);
    cyc(1);  chk("k0_rel_drop", int'(key_pressed), 0);
    chk("k0_rel_cols", int'(cols_n), 4'b1011);

    // Rows 0 and 2 together in col3: row0 (key A) wins
    keys[3]  = 1'b1;
    keys[11] = 1'b1;
    cyc(15); chk("kA_kv_early", int'(key_valid), 0);
    cyc(1);  chk("kA_kv", int'(key_valid), 1);
    chk("kA_key", int'(key), 4'hA);
    chk("kA_kp", int'(key_pressed), 1);
    chk("kA_cols", int'(cols_n), 4'b0111);
    cyc(1);  chk("kA_kv_one", int'(key_valid), 0);
    chk("kA_pulses", pulses, 3);
    cyc(1);

    // Reset while HELD
    #2 reset = 1'b0;
    #1;
    chk("hrst_cols", int'(cols_n), 4'b1110);
    chk("hrst_key", int'(key), 0);
    chk("hrst_kv", int'(key_valid), 0);
    chk("hrst_kp", int'(key_pressed), 0);
    keys = 16'h0000;
    cyc(1);
    reset = 1'b1;
    cyc(3);  chk("post_rst_c0", int'(cols_n), 4'b1110);
    cyc(1);  chk("post_rst_c1", int'(cols_n), 4'b1101);
    chk("final_pulses", pulses, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
